ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset).
- It is the opposite direction of the keyboard receive path and shares the same two open-drain lines.
- It drives each line low only through an output-enable; board tristate logic outputs 0 when the enable is 1 and releases the line otherwise.
- It sits beside the PS/2 receiver, is fed by a CPU-mapped I/O register, and gates the receiver through rx_inhibit while a transfer is in progress.

Parameters:
- INHIBIT_CYCLES, 5000, time clock is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, limit from clock release to end of transaction (20 ms).
- FILTER_CYCLES, 8, consecutive identical samples needed before the filtered ps2_clk changes.

Ports:
- clk_50MHz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  block idle and able to accept a byte.
- ps2_clk_in  in  1  raw PS/2 clock line, asynchronous.
- ps2_data_in  in  1  raw PS/2 data line, asynchronous.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low.
- ps2_data_oe  out  1  1 = pull PS/2 data low.
- busy  out  1  transaction in progress.
- rx_inhibit  out  1  receiver must discard frames while high; equals busy.
- done  out  1  one-cycle pulse: byte sent and ACK received.
- ack_err  out  1  one-cycle pulse: device did not ACK.
- timeout_err  out  1  one-cycle pulse: transaction exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs are 0 except tx_ready, which is 1; state is IDLE.
  - Assertion mid-transaction releases both lines immediately, with no clock edge needed.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
  - The clock path is then glitch-filtered with FILTER_CYCLES.
  - fall is a one-cycle pulse on each filtered 1->0 transition.
- Handshake:
  - A byte is accepted on a rising clk_50MHz edge with tx_valid=1 and tx_ready=1.
  - tx_data is latched into shift[7:0] and the parity bit is latched as ~^tx_data (odd parity).
  - tx_ready drops the next cycle. tx_valid is ignored while tx_ready=0.
- State machine:
  - IDLE: oe outputs 0. On accept go to INHIBIT, clearing the cycle counter.
  - INHIBIT: ps2_clk_oe=1. After INHIBIT_CYCLES cycles go to RTS.
  - RTS (request-to-send): ps2_data_oe=1 (start bit 0) and ps2_clk_oe=0. Clear the timeout counter and the bit counter; go to XFER.
  - XFER: count falls n=1..10.
    - Falls 1-8: ps2_data_oe = ~bit[n-1], data bits sent LSB first.
    - Fall 9: ps2_data_oe = ~parity.
    - Fall 10: ps2_data_oe=0, which releases the line as the stop bit; go to ACK.
    - Data changes only in the cycle after a fall, while the device clock is low.
  - ACK: on fall 11, sample synchronized data. 0 records ACK ok, 1 records ack error. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clock and synchronized data are both 1.
    - Then pulse exactly one of done or ack_err, set tx_ready=1 and go to IDLE in the same cycle.
- Timeout:
  - The counter runs in RTS, XFER, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES, both oe outputs go to 0, timeout_err pulses, and the next state is IDLE with tx_ready=1.
  - If timeout and completion occur in the same cycle, timeout_err takes priority and done/ack_err are suppressed.
- Falls in IDLE or INHIBIT are ignored; this covers keyboard traffic and the host's own inhibit edge.
- busy = rx_inhibit = (state != IDLE).
- Never drive both oe outputs to 1 except during the transition INHIBIT->RTS. For exactly one cycle, data is pulled low before clock is released.

Test Plan:
- Reset with rst_n=0 mid-XFER:
  - ps2_clk_oe and ps2_data_oe fall to 0 asynchronously.
  - After release: tx_ready=1, busy=0, no pulses.
- Send 0xED against a device model clocking at 80 us/bit (4000 cycles):
  - Clock is held low for exactly 5000 cycles.
  - Bits sampled on device rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device ACKs with 0, then done pulses for 1 cycle and tx_ready=1.
- Send 0xF4:
  - Parity bit sampled is 0.
  - Device drives data=1 at the 11th fall; ack_err pulses, done stays 0.
- Device never clocks after RTS:
  - At TIMEOUT_CYCLES after RTS, timeout_err pulses, both lines are released, IDLE is reached.
- Hold tx_valid=1 with tx_data=0xFF, then change tx_data to 0x00 during XFER:
  - Transmitted byte is 0xFF.
  - A second byte is accepted only after done.
- Inject 3-cycle glitches on ps2_clk_in during XFER:
  - No extra bit is counted; frame content is unchanged; done pulses.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clocked-out frame,
// ACK check and transaction timeout, driving the open-drain lines through output enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int CW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  // The RTS cycle still holds the clock low, so INHIBIT itself lasts one cycle less.
  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, XFER, ACK, WAIT_IDLE} state_t;

  state_t        state;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          data_s;
  logic          clk_filt;
  logic          fall;
  logic [FW-1:0] filt_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic [3:0]    bit_cnt;
  logic          ack_bad;
  logic [CW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          timed_out;

  assign data_s     = data_sync[1];
  assign timed_out  = (to_cnt == TO_LAST);
  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rx_inhibit = busy;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  // Filtered clock follows the synchronized line only after FILTER_CYCLES agreeing samples.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      shift       <= '0;
      parity      <= 1'b0;
      bit_cnt     <= '0;
      ack_bad     <= 1'b0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shift      <= tx_data;
            parity     <= ~^tx_data;
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        RTS: begin
          ps2_clk_oe <= 1'b0;
          to_cnt     <= '0;
          bit_cnt    <= '0;
          state      <= XFER;
        end
        default: begin
          to_cnt <= to_cnt + 1'b1;
          // Timeout wins over any completion that lands in the same cycle.
          if (timed_out) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            case (state)
              XFER: begin
                if (fall) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt < 4'd8) begin
                    ps2_data_oe <= ~shift[0];
                    shift       <= {1'b0, shift[7:1]};
                  end else if (bit_cnt == 4'd8) begin
                    ps2_data_oe <= ~parity;
                  end else begin
                    ps2_data_oe <= 1'b0;
                    state       <= ACK;
                  end
                end
              end
              ACK: begin
                if (fall) begin
                  ack_bad <= data_s;
                  state   <= WAIT_IDLE;
                end
              end
              WAIT_IDLE: begin
                if (clk_filt && data_s) begin
                  done    <= ~ack_bad;
                  ack_err <= ack_bad;
                  state   <= IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and the sampled bits, pulses and line enables are compared against hand-computed values.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int TOUT = 3000;
  localparam int FILT = 8;
  localparam int HALF = 40;

  logic       clk_50MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, done, ack_err, timeout_err;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk = 1'b1;
  logic       dev_data_low = 1'b0;
  logic       glitch = 1'b0;

  // Open-drain lines: either side can pull low.
  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk & ~glitch;
  assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, ackerr_cnt = 0, tout_cnt = 0, clk_low_cnt = 0, overlap_cnt = 0;
  int base_done, base_ackerr, base_tout, base_clk_low, base_overlap;
  logic [10:0] bits;
  int cycles;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TOUT),
    .FILTER_CYCLES (FILT)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .rx_inhibit (rx_inhibit),
    .done       (done),
    .ack_err    (ack_err),
    .timeout_err(timeout_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(negedge clk_50MHz) begin
    if (done)        done_cnt++;
    if (ack_err)     ackerr_cnt++;
    if (timeout_err) tout_cnt++;
    if (ps2_clk_oe)  clk_low_cnt++;
    if (ps2_clk_oe && ps2_data_oe) overlap_cnt++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic snapshot();
    base_done    = done_cnt;
    base_ackerr  = ackerr_cnt;
    base_tout    = tout_cnt;
    base_clk_low = clk_low_cnt;
    base_overlap = overlap_cnt;
  endtask

  // One-cycle request, called at a negedge.
  task automatic applyStimulus(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    waitCycles(1);
    tx_valid = 1'b0;
    checkOutput("accept_busy", busy, 1);
    checkOutput("accept_ready", tx_ready, 0);
    checkOutput("accept_rx_inhibit", rx_inhibit, 1);
  endtask

  task automatic waitXfer();
    int guard = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && guard < 5000) begin
      waitCycles(1);
      guard++;
    end
    checkOutput("rts_seen", guard < 5000, 1);
  endtask

  // Device side of a host-to-device frame; bits[0] is the start bit, bits[10] the stop bit.
  task automatic deviceFrame(input bit ack_ok, input bit with_glitch, output logic [10:0] fb);
    fb = '0;
    waitXfer();
    waitCycles(HALF);
    fb[0] = ps2_data_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      waitCycles(HALF);
      fb[k] = ps2_data_in;
      dev_clk = 1'b1;
      if (with_glitch) begin
        waitCycles(12);
        glitch = 1'b1;
        waitCycles(3);
        glitch = 1'b0;
        waitCycles(HALF - 15);
      end else begin
        waitCycles(HALF);
      end
    end
    dev_data_low = ack_ok;
    waitCycles(5);
    dev_clk = 1'b0;
    waitCycles(HALF);
    dev_clk = 1'b1;
    waitCycles(5);
    dev_data_low = 1'b0;
  endtask

  task automatic waitFinish(output int n);
    n = 0;
    while (!(done || ack_err || timeout_err) && n < 500) begin
      waitCycles(1);
      n++;
    end
    checkOutput("finish_seen", n < 500, 1);
  endtask

  initial begin
    // Reset values while rst_n is held low.
    waitCycles(3);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rx_inhibit", rx_inhibit, 0);
    checkOutput("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    checkOutput("rst_pulses", {done, ack_err, timeout_err}, 0);
    rst_n = 1'b1;
    waitCycles(2);

    // Asynchronous reset during INHIBIT releases the clock line without an edge.
    applyStimulus(8'h00);
    waitCycles(10);
    checkOutput("inh_clk_oe", ps2_clk_oe, 1);
    #3 rst_n = 1'b0;
    #1 checkOutput("inh_rst_clk_oe", ps2_clk_oe, 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);

    // Asynchronous reset mid-XFER releases the data line.
    snapshot();
    applyStimulus(8'h00);
    waitXfer();
    waitCycles(HALF);
    for (int k = 0; k < 3; k++) begin
      dev_clk = 1'b0;
      waitCycles(HALF);
      dev_clk = 1'b1;
      waitCycles(HALF);
    end
    checkOutput("xfer_data_oe", ps2_data_oe, 1);
    #3 rst_n = 1'b0;
    #1 checkOutput("xfer_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(3);
    checkOutput("post_rst_ready", tx_ready, 1);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_pulses", done_cnt + ackerr_cnt + tout_cnt - base_done - base_ackerr - base_tout, 0);

    // 0xED (odd parity 1) with ACK.
    snapshot();
    applyStimulus(8'hED);
    deviceFrame(1'b1, 1'b0, bits);
    checkOutput("ed_frame", bits, 11'b1_1_11101101_0);
    waitFinish(cycles);
    checkOutput("ed_done", done, 1);
    checkOutput("ed_ready", tx_ready, 1);
    waitCycles(3);
    checkOutput("ed_done_pulses", done_cnt - base_done, 1);
    checkOutput("ed_ackerr_pulses", ackerr_cnt - base_ackerr, 0);
    checkOutput("ed_clk_low_cycles", clk_low_cnt - base_clk_low, INH);
    checkOutput("ed_overlap_cycles", overlap_cnt - base_overlap, 1);
    checkOutput("ed_busy_after", busy, 0);

    // 0xF4 (odd parity 0), device does not ACK.
    snapshot();
    applyStimulus(8'hF4);
    deviceFrame(1'b0, 1'b0, bits);
    checkOutput("f4_frame", bits, 11'b1_0_11110100_0);
    checkOutput("f4_parity", bits[9], 0);
    waitFinish(cycles);
    checkOutput("f4_ack_err", ack_err, 1);
    waitCycles(3);
    checkOutput("f4_ackerr_pulses", ackerr_cnt - base_ackerr, 1);
    checkOutput("f4_done_pulses", done_cnt - base_done, 0);

    // Silent device: timeout counted from clock release.
    snapshot();
    applyStimulus(8'h55);
    cycles = 0;
    while (ps2_clk_oe && cycles < INH + 20) begin
      waitCycles(1);
      cycles++;
    end
    checkOutput("to_release_seen", cycles < INH + 20, 1);
    cycles = 0;
    while (!timeout_err && cycles < TOUT + 100) begin
      waitCycles(1);
      cycles++;
    end
    checkOutput("to_cycles", cycles, TOUT);
    checkOutput("to_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    checkOutput("to_ready", tx_ready, 1);
    waitCycles(3);
    checkOutput("to_pulses", tout_cnt - base_tout, 1);
    checkOutput("to_other_pulses", done_cnt + ackerr_cnt - base_done - base_ackerr, 0);
    checkOutput("to_busy", busy, 0);

    // Held tx_valid: data change mid-frame is ignored, next byte waits for done.
    snapshot();
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    waitCycles(1);
    checkOutput("hold_busy", busy, 1);
    waitXfer();
    tx_data = 8'h00;
    deviceFrame(1'b1, 1'b0, bits);
    checkOutput("hold_frame_ff", bits, 11'b1_1_11111111_0);
    checkOutput("hold_not_ready", tx_ready, 0);
    waitFinish(cycles);
    checkOutput("hold_done", done, 1);
    checkOutput("hold_ready_at_done", tx_ready, 1);
    waitCycles(1);
    checkOutput("hold_second_accept", busy, 1);
    tx_valid = 1'b0;
    deviceFrame(1'b1, 1'b0, bits);
    checkOutput("hold_frame_00", bits, 11'b1_1_00000000_0);
    waitFinish(cycles);
    waitCycles(3);
    checkOutput("hold_done_pulses", done_cnt - base_done, 2);

    // 3-cycle clock glitches inside every high phase are filtered out.
    snapshot();
    applyStimulus(8'hA5);
    deviceFrame(1'b1, 1'b1, bits);
    checkOutput("glitch_frame", bits, 11'b1_1_10100101_0);
    waitFinish(cycles);
    waitCycles(3);
    checkOutput("glitch_done_pulses", done_cnt - base_done, 1);
    checkOutput("glitch_ackerr_pulses", ackerr_cnt - base_ackerr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
